// File: rtl/mul_fifo_pkg.sv
// Shared constants, operand-pair type and stage-slice helper for the multiplier operand FIFO.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mul_fifo_pkg;

  // Default geometry: IEEE single operands, 4-entry FIFO, 3-stage multiplier.
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_NUM_STG = 3;

  // Operand pair at the default width, {a, b} with a in the upper half.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
  } opnd_pair_t;

  // LSB of stage k inside a flattened NUM_STG*WIDTH stage bus.
  function automatic int stg_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/mul_fifo_ram.sv
// Operand-pair storage: DEPTH x (2*WIDTH) words, one write port, one asynchronous read port.
// Latency: write lands on the clock edge; read data follows rd_addr combinationally.
// Backpressure: none here; the caller only writes when an entry is free.
module mul_fifo_ram
  import mul_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [2*WIDTH-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [2*WIDTH-1:0] rd_data
);

  // Contents are never reset; only entries that have been written are ever issued.
  logic [2*WIDTH-1:0] mem [DEPTH];

  // Single write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mul_operand_fifo.sv
// Operand FIFO feeding a NUM_STG-deep pipelined multiplier through an adv-driven operand/valid shift chain.
// Latency: a pair pushed at edge N reaches stage 0 at the next adv edge once it is at the head (no empty bypass).
// Backpressure: in_ready = ~full & ~flush; adv with an empty FIFO inserts a bubble. Macro MUL_FIFO_ERR_FLAGS_EN adds ovf_err/udf_err.
module mul_operand_fifo
  import mul_fifo_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int NUM_STG = DEF_NUM_STG,
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       clear_b,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a_in,
  input  logic [WIDTH-1:0]           b_in,
  input  logic                       adv,
  output logic [NUM_STG*WIDTH-1:0]   stg_a,
  output logic [NUM_STG*WIDTH-1:0]   stg_b,
  output logic [NUM_STG-1:0]         stg_vld,
  output logic [CNT_W-1:0]           count,
  output logic                       full,
  output logic                       empty
`ifdef MUL_FIFO_ERR_FLAGS_EN
  ,
  output logic                       ovf_err,
  output logic                       udf_err
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             push;
  logic             pop;
  pair_t            wr_pair;
  pair_t            rd_pair;

  logic [WIDTH-1:0]   sa_q [NUM_STG];
  logic [WIDTH-1:0]   sb_q [NUM_STG];
  logic [NUM_STG-1:0] vld_q;

  // Status is derived from the registered count, so it is clean straight out of reset.
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;

  // No pass-through when full: a same-cycle pop does not open a slot for the push.
  assign in_ready = ~full & ~flush;
  assign push     = in_valid & in_ready;
  assign pop      = adv & ~empty & ~flush;

  assign wr_pair  = {a_in, b_in};

  mul_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_pair),
    .rd_addr (rd_ptr),
    .rd_data (rd_pair)
  );

  // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Stage chain: shifts on adv; stage 0 takes the head pair or a bubble that keeps its old data.
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      for (int k = 0; k < NUM_STG; k++) begin
        sa_q[k] <= '0;
        sb_q[k] <= '0;
      end
      vld_q <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else if (adv) begin
      for (int k = 1; k < NUM_STG; k++) begin
        sa_q[k]  <= sa_q[k-1];
        sb_q[k]  <= sb_q[k-1];
        vld_q[k] <= vld_q[k-1];
      end
      if (pop) begin
        sa_q[0] <= rd_pair.a;
        sb_q[0] <= rd_pair.b;
      end
      vld_q[0] <= pop;
    end
  end

  // Flatten the per-stage registers onto the packed stage buses.
  always_comb begin
    stg_a = '0;
    stg_b = '0;
    for (int k = 0; k < NUM_STG; k++) begin
      stg_a[stg_lsb(k, WIDTH) +: WIDTH] = sa_q[k];
      stg_b[stg_lsb(k, WIDTH) +: WIDTH] = sb_q[k];
    end
  end

  assign stg_vld = vld_q;

`ifdef MUL_FIFO_ERR_FLAGS_EN
  // Sticky error flags: offered while full, or a bubble entering a chain that still holds live pairs.
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else if (flush) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (in_valid && full) begin
        ovf_err <= 1'b1;
      end
      if (adv && empty && (|vld_q)) begin
        udf_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mul_operand_fifo.sv
// Bench for mul_operand_fifo: directed vector table, hand sequences for corner cases, randomized run vs a queue model.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_mul_operand_fifo;
  import mul_fifo_pkg::*;

  localparam int W  = DEF_WIDTH;
  localparam int D  = DEF_DEPTH;
  localparam int S  = DEF_NUM_STG;
  localparam int CW = $clog2(D) + 1;

  logic           clk = 1'b0;
  logic           clear_b;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic           adv;
  logic [S*W-1:0] stg_a;
  logic [S*W-1:0] stg_b;
  logic [S-1:0]   stg_vld;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;
`ifdef MUL_FIFO_ERR_FLAGS_EN
  logic           ovf_err;
  logic           udf_err;
`endif

  mul_operand_fifo dut (
    .clk      (clk),
    .clear_b  (clear_b),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .b_in     (b_in),
    .adv      (adv),
    .stg_a    (stg_a),
    .stg_b    (stg_b),
    .stg_vld  (stg_vld),
    .count    (count),
    .full     (full),
    .empty    (empty)
`ifdef MUL_FIFO_ERR_FLAGS_EN
    ,
    .ovf_err  (ovf_err),
    .udf_err  (udf_err)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of pending pairs plus an array of stage slots.
  opnd_pair_t   mq[$];
  logic [W-1:0] ma [S];
  logic [W-1:0] mb [S];
  logic [S-1:0] mvld;
  logic         m_ovf;
  logic         m_udf;

  typedef struct {
    bit           v;
    logic [W-1:0] a;
    bit           ad;
    logic [CW-1:0] e_cnt;
    logic [S-1:0] e_vld;
    logic [W-1:0] e_a0;
    logic [W-1:0] e_a2;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input int v, input int a, input int ad, input int cnt,
                              input int vld, input int a0, input int a2);
    vec_t t;
    t.v     = (v != 0);
    t.a     = W'(a);
    t.ad    = (ad != 0);
    t.e_cnt = CW'(cnt);
    t.e_vld = S'(vld);
    t.e_a0  = W'(a0);
    t.e_a2  = W'(a2);
    return t;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < S; k++) begin
      ma[k] = '0;
      mb[k] = '0;
    end
    mvld  = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit         do_push;
    bit         do_pop;
    opnd_pair_t hd;
    opnd_pair_t np;
    do_push = in_valid && (mq.size() < D) && !flush;
    do_pop  = adv && (mq.size() > 0) && !flush;
    if (flush) begin
      mq.delete();
      mvld  = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (in_valid && mq.size() == D) m_ovf = 1'b1;
      if (adv && mq.size() == 0 && mvld != '0) m_udf = 1'b1;
      if (adv) begin
        for (int k = S - 1; k >= 1; k--) begin
          ma[k]   = ma[k-1];
          mb[k]   = mb[k-1];
          mvld[k] = mvld[k-1];
        end
        if (do_pop) begin
          hd    = mq.pop_front();
          ma[0] = hd.a;
          mb[0] = hd.b;
        end
        mvld[0] = do_pop;
      end
      if (do_push) begin
        np.a = a_in;
        np.b = b_in;
        mq.push_back(np);
      end
    end
  endtask

  task automatic model_check(input string tag);
    logic [S*W-1:0] ea;
    logic [S*W-1:0] eb;
    for (int k = 0; k < S; k++) begin
      ea[k*W +: W] = ma[k];
      eb[k*W +: W] = mb[k];
    end
    chk({tag, ".count"}, 128'(count), 128'(mq.size()));
    chk({tag, ".full"},  128'(full),  128'(mq.size() == D));
    chk({tag, ".empty"}, 128'(empty), 128'(mq.size() == 0));
    chk({tag, ".vld"},   128'(stg_vld), 128'(mvld));
    chk({tag, ".stg_a"}, 128'(stg_a), 128'(ea));
    chk({tag, ".stg_b"}, 128'(stg_b), 128'(eb));
`ifdef MUL_FIFO_ERR_FLAGS_EN
    chk({tag, ".ovf"}, 128'(ovf_err), 128'(m_ovf));
    chk({tag, ".udf"}, 128'(udf_err), 128'(m_udf));
`endif
  endtask

  // Apply inputs just after an edge, check in_ready, take the next edge, step the model.
  task automatic cycle(input bit v, input int a, input int b, input bit ad, input bit fl);
    in_valid = v;
    a_in     = W'(a);
    b_in     = W'(b);
    adv      = ad;
    flush    = fl;
    #1;
    chk("in_ready", 128'(in_ready), 128'((mq.size() != D) && !fl));
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    int unsigned got[$];

    clear_b  = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    adv      = 1'b0;
    a_in     = '0;
    b_in     = '0;
    model_reset();
    #12;
    chk("rst.count", 128'(count), 128'(0));
    chk("rst.empty", 128'(empty), 128'(1));
    chk("rst.full",  128'(full),  128'(0));
    chk("rst.vld",   128'(stg_vld), 128'(0));
    chk("rst.in_ready", 128'(in_ready), 128'(1));
    clear_b = 1'b1;
    @(posedge clk);
    #1;

    // Directed fill then drain: {valid, a, adv, count, vld, stage0 a, stage2 a}.
    tbl[0]  = mk(0, 0, 0, 0, 3'b000, 0, 0);
    tbl[1]  = mk(1, 1, 0, 1, 3'b000, 0, 0);
    tbl[2]  = mk(1, 2, 0, 2, 3'b000, 0, 0);
    tbl[3]  = mk(1, 3, 0, 3, 3'b000, 0, 0);
    tbl[4]  = mk(1, 4, 0, 4, 3'b000, 0, 0);
    tbl[5]  = mk(1, 5, 0, 4, 3'b000, 0, 0);
    tbl[6]  = mk(0, 0, 1, 3, 3'b001, 1, 0);
    tbl[7]  = mk(0, 0, 1, 2, 3'b011, 2, 0);
    tbl[8]  = mk(0, 0, 1, 1, 3'b111, 3, 1);
    tbl[9]  = mk(0, 0, 1, 0, 3'b111, 4, 2);
    tbl[10] = mk(0, 0, 1, 0, 3'b110, 4, 3);
    tbl[11] = mk(0, 0, 1, 0, 3'b100, 4, 4);
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].v, int'(tbl[i].a), int'(tbl[i].a) * 10, tbl[i].ad, 1'b0);
      chk("tbl.count", 128'(count), 128'(tbl[i].e_cnt));
      chk("tbl.full",  128'(full),  128'(tbl[i].e_cnt == CW'(D)));
      chk("tbl.empty", 128'(empty), 128'(tbl[i].e_cnt == '0));
      chk("tbl.vld",   128'(stg_vld), 128'(tbl[i].e_vld));
      chk("tbl.a0",    128'(stg_a[0 +: W]), 128'(tbl[i].e_a0));
      chk("tbl.b0",    128'(stg_b[0 +: W]), 128'(tbl[i].e_a0 * 10));
      chk("tbl.a2",    128'(stg_a[2*W +: W]), 128'(tbl[i].e_a2));
    end
`ifdef MUL_FIFO_ERR_FLAGS_EN
    chk("fill.ovf_err", 128'(ovf_err), 128'(1));
`endif
    model_check("after_table");

    // Streaming: 12 pairs with push and adv every cycle, three pointer wraps.
    cycle(1'b0, 0, 0, 1'b0, 1'b1);
    model_check("pre_stream");
    for (int i = 0; i < 15; i++) begin
      cycle(i < 12, 100 + i, 200 + i, 1'b1, 1'b0);
      if (i < 12) chk("stream.count", 128'(count), 128'(1));
      if (stg_vld[2]) got.push_back(stg_a[2*W +: W]);
      model_check("stream");
    end
    chk("stream.n_out", 128'(got.size()), 128'(12));
    for (int i = 0; i < 12 && i < got.size(); i++) begin
      chk("stream.order", 128'(got[i]), 128'(100 + i));
    end

    // Bubble: a single pair, then adv with the FIFO empty.
    cycle(1'b0, 0, 0, 1'b0, 1'b1);
    cycle(1'b1, 7, 70, 1'b0, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    chk("bubble.st0_7", 128'(stg_a[0 +: W]), 128'(7));
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    chk("bubble.vld0", 128'(stg_vld[0]), 128'(0));
    chk("bubble.st1_a", 128'(stg_a[W +: W]), 128'(7));
    chk("bubble.st1_b", 128'(stg_b[W +: W]), 128'(70));
`ifdef MUL_FIFO_ERR_FLAGS_EN
    chk("bubble.udf_err", 128'(udf_err), 128'(1));
`endif
    model_check("bubble");

    // Flush with count 3 and a full chain, then a fresh push.
    cycle(1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) cycle(1'b1, i, 10 * i, 1'b0, 1'b0);
    cycle(1'b1, 5, 50, 1'b1, 1'b0);
    cycle(1'b1, 6, 60, 1'b1, 1'b0);
    cycle(1'b1, 7, 70, 1'b1, 1'b0);
    chk("preflush.count", 128'(count), 128'(3));
    chk("preflush.vld",   128'(stg_vld), 128'(3'b111));
    cycle(1'b1, 8, 80, 1'b1, 1'b1);
    chk("flush.count", 128'(count), 128'(0));
    chk("flush.vld",   128'(stg_vld), 128'(0));
    chk("flush.empty", 128'(empty), 128'(1));
    cycle(1'b1, 9, 90, 1'b0, 1'b0);
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    chk("postflush.a0",  128'(stg_a[0 +: W]), 128'(9));
    chk("postflush.vld", 128'(stg_vld), 128'(3'b001));
    model_check("postflush");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(bit'($urandom_range(0, 3) != 0), int'($urandom), int'($urandom),
            bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 31) == 0));
      model_check("rand");
    end

    // Asynchronous reset mid-stream, asserted between clock edges.
    for (int i = 0; i < 4; i++) cycle(1'b1, 300 + i, 400 + i, 1'b1, 1'b0);
    in_valid = 1'b0;
    adv      = 1'b0;
    #2;
    clear_b = 1'b0;
    #1;
    chk("arst.vld",   128'(stg_vld), 128'(0));
    chk("arst.count", 128'(count), 128'(0));
    chk("arst.empty", 128'(empty), 128'(1));
    chk("arst.full",  128'(full), 128'(0));
    chk("arst.stg_a", 128'(stg_a), 128'(0));
    chk("arst.stg_b", 128'(stg_b), 128'(0));
    model_reset();
    #2;
    clear_b = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 'h55, 'h66, 1'b0, 1'b0);
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    chk("arst.first_a", 128'(stg_a[0 +: W]), 128'('h55));
    model_check("post_arst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_operand_fifo.md
Name: mul_operand_fifo

Overview:
- Parametrised operand FIFO for the Goldschmidt datapath.
- Buffers (A, B) operand pairs, e.g. K_i with D or N, using a valid/ready write port.
- Feeds a NUM_STG-deep pipelined array multiplier through a per-stage operand/valid shift chain advanced by the multiplier's stall-free `adv` strobe.
- Adds depth, width and stage-count generality, full/empty/count status, bubble insertion, flush, and asynchronous reset.

Parameters:
- WIDTH, 32, operand width in bits (IEEE single by default).
- DEPTH, 4, FIFO entries; must be a power of two, >= 2.
- NUM_STG, 3, number of multiplier stages fed; >= 1.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  rising-edge clock.
- clear_b  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of FIFO contents and stage valids.
- in_valid  in  1  producer has an operand pair.
- in_ready  out  1  FIFO accepts the pair this cycle.
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B.
- adv  in  1  multiplier pipeline advances this cycle.
- stg_a  out  NUM_STG*WIDTH  A for stage k at bits [k*WIDTH +: WIDTH].
- stg_b  out  NUM_STG*WIDTH  B for stage k, same packing as stg_a.
- stg_vld  out  NUM_STG  bit k = stage k holds a real operand pair.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (clear_b low, asynchronous): rd_ptr, wr_ptr, count = 0; stg_a/stg_b = 0; stg_vld = 0; full = 0; empty = 1. Storage RAM is not reset. Outputs never drive X or Z.
- Write: push = in_valid & in_ready, with in_ready = ~full & ~flush. Full gives no pass-through: a push and a pop in the same cycle while full is not accepted.
- On push, entry[wr_ptr] <= {a_in, b_in} and wr_ptr increments, wrapping modulo DEPTH.
- Issue: pop = adv & ~empty & ~flush.
- On adv, the chain shifts: stage k <= stage k-1 for k >= 1.
- On adv, stage 0 <= entry[rd_ptr] with vld = 1 if pop occurs; otherwise stage 0 receives a bubble: vld = 0 and a/b hold their previous value.
- rd_ptr increments on pop, wrapping modulo DEPTH.
- adv low: the whole chain holds; nothing pops.
- count update: +1 on push only, -1 on pop only, unchanged when push and pop occur together (legal whenever not full and not empty).
- Latency: a pair pushed at edge N is first visible in stage 0 after edge N+1 if adv is high at N+1 and it is at the head. Empty-FIFO bypass is not supported.
- Stage k holds a pair exactly k adv-edges after it entered stage 0.
- flush (synchronous, higher priority than push and pop): pointers and count <= 0, stg_vld <= 0; a/b data are left as-is.
- Reset mid-operation discards all in-flight pairs; the first push after release lands in entry 0.

Optional Feature:
- Macro: MUL_FIFO_ERR_FLAGS_EN.
- When defined, adds outputs `ovf_err` and `udf_err` (1 bit each), both sticky and cleared by reset or flush.
- ovf_err sets when in_valid & full; udf_err sets when adv & empty & (any stg_vld bit set), i.e. a bubble enters mid-stream.
- When not defined, those ports and their logic are absent and the behaviour above is unchanged.

Decomposition:
- Package `mul_fifo_pkg`: default WIDTH/DEPTH/NUM_STG constants; an operand-pair typedef {a, b}; the stage-slice index function.
- One sub-module, `mul_fifo_ram`: DEPTH x 2*WIDTH storage with 1 write port and 1 asynchronous read port, no reset.
- Pointers, count and the stage chain stay in the top level.

Test Plan:
- Reset then idle: stg_vld = 000, count = 0, empty = 1, in_ready = 1. Assert clear_b low mid-stream: outputs return to 0 within the same cycle, with no clock edge required.
- Fill: push 1,2,3,4 (b = 10*a) with adv = 0 -> count = 4, full = 1, in_ready = 0. A 5th in_valid is not accepted; with the macro enabled, ovf_err = 1.
- Drain: adv = 1 for 6 cycles after the fill -> stage0 a sequence 1,2,3,4. stg_vld goes 001,011,111,111,110,100. stage2 shows a = 1 on cycle 3.
- Streaming: continuous push plus adv with DEPTH = 4, across 12 pairs spanning 3 pointer wraps -> count stays at 1 and order is preserved at stage 2.
- Bubble: push 7, wait, then adv with FIFO empty after 7 is issued -> stage0 vld = 0 while stage1 holds 7; with the macro enabled, udf_err = 1.
- Flush with count = 3 and stg_vld = 111 -> next cycle count = 0, stg_vld = 000, empty = 1. A following push of 9 reaches stage0 after one adv.
